serial_word_collector: RTL
==========================

Name: serial_word_collector

Overview:
- Downstream consumer of the 2:1 bit-select mux output.
- Accepts the selected bit stream one bit per handshake and assembles WIDTH-bit words.
- Presents each assembled word on a valid/ready output port, with one pending-word buffer so the bit stream keeps flowing while the sink stalls.
- Sits between the mux and the word-wide result/IO logic.

Parameters:
- WIDTH, 8, bits per assembled word (≥2).
- MSB_FIRST, 0: 0 = first bit of a frame lands in word_out[0]; 1 = first bit lands in word_out[WIDTH-1].

Ports:
- clk  input  1  single clock, all state on rising edge
- reset  input  1  synchronous, active-high
- bit_in  input  1  serial data bit (the mux output)
- bit_valid  input  1  bit_in is valid this cycle
- bit_ready  output  1  collector can accept a bit this cycle
- start  input  1  sideband: accepted bit is bit 0 of a new frame
- word_out  output  WIDTH  assembled word, registered
- word_valid  output  1  word_out holds an unconsumed word
- word_ready  input  1  sink accepts word_out this cycle
- bit_count  output  clog2(WIDTH)+1  bits currently held in the shift register (0..WIDTH)
- abort  output  1  one-cycle pulse: partial frame discarded

Behaviour:
- Clock and reset:
  - One clock. Reset is synchronous and active-high.
  - With reset high at a rising edge: shift register = 0, bit_count = 0, pending flag = 0, word_out = 0, word_valid = 0, abort = 0.
  - bit_ready is forced 0 while reset is high.
- Accept rule: a bit is accepted on a cycle with bit_valid && bit_ready. Every non-accepted cycle changes no collector state.
- Bit placement:
  - Bit k of a frame (k = 0..WIDTH-1) is written to shift position k if MSB_FIRST=0, or to WIDTH-1-k if MSB_FIRST=1.
  - bit_count increments on each accept.
- Word completion: the accept that makes bit_count reach WIDTH completes the word.
  - If the output register is free this cycle (word_valid==0, or word_valid && word_ready), the word moves into word_out on that same edge. word_valid=1 next cycle, bit_count returns to 0. Latency is 1 cycle from the last accepted bit to word_valid.
  - Otherwise the word stays in the shift register: pending=1, bit_count=WIDTH.
- Pending state:
  - bit_ready = !reset && !pending.
  - When word_valid && word_ready with pending=1: the pending word loads word_out, word_valid stays 1, pending clears, bit_count goes to 0. bit_ready rises the next cycle.
- Output drain:
  - word_valid && word_ready with nothing pending and no completion in that cycle: word_valid clears next cycle. word_out holds its last value.
  - Simultaneous drain and completion gives back-to-back words with no bubble.
- word_out stability: word_out is stable while word_valid=1 and word_ready=0.
- Start sideband:
  - Sampled only on accepted bits; start without an accept is ignored.
  - Accepted bit with start=1 and bit_count==0: normal frame start, no abort.
  - Accepted bit with start=1 and 0<bit_count<WIDTH: partial bits discarded. abort=1 for exactly the next cycle. The accepted bit becomes bit 0 of the new frame (bit_count=1 next cycle).
  - start cannot hit a pending word, because bit_ready=0 while pending.
- Counters: bit_count saturates structurally at WIDTH. Wrap to 0 only on transfer to word_out. No overflow path.
- Reset mid-operation: a partial word, the pending word and word_out are all dropped. No word_valid or abort pulse is produced by reset.

Test Plan:
- WIDTH=8, MSB_FIRST=0, word_ready=1; stream bits 1,0,1,1,0,0,1,0 continuous, start on first -> word_out=8'h4D, word_valid=1 for exactly 1 cycle, one cycle after the 8th accepted bit. bit_count steps 1..7 then 0.
- Same bits with MSB_FIRST=1 -> word_out=8'hB2.
- Backpressure, word_ready=0: stream 8'hA5 then 8'h3C continuously -> word_out holds 8'hA5. After 16 accepts: pending, bit_ready=0, bit_count=8. Raise word_ready one cycle -> word_out=8'h3C the next cycle, word_valid stays 1, bit_ready=1 a cycle later.
- Mid-frame restart: 3 bits accepted, then accepted bit with start=1 -> abort=1 for one cycle, bit_count=1. Complete 7 more bits -> one word containing only the new frame.
- bit_valid gaps: random idle cycles between bits of 8'hF0 -> identical 8'hF0 result. bit_count unchanged on idle cycles.
- Reset asserted after 5 bits and with word_valid=1 -> next cycle all outputs 0. Fresh frame 8'h01 -> word_out=8'h01 with correct timing.

Source files
------------

// File: rtl/serial_word_collector.sv
// Serial-to-parallel word collector: gathers one bit per handshake into WIDTH-bit
// words and presents them on a registered valid/ready port with a one-word pending buffer.
module serial_word_collector #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     bit_in,
  input  logic                     bit_valid,
  output logic                     bit_ready,
  input  logic                     start,
  output logic [WIDTH-1:0]         word_out,
  output logic                     word_valid,
  input  logic                     word_ready,
  output logic [$clog2(WIDTH):0]   bit_count,
  output logic                     abort
);

  localparam int CW = $clog2(WIDTH) + 1;

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; valid never waits on ready, and data is held while valid && !ready.

  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] next_word;
  logic [CW-1:0]    base;
  logic             pending;
  logic             accept;
  logic             restart;
  logic             out_free;
  logic             drain;
  logic             complete;
  int               pos;

  assign bit_ready = !reset && !pending;
  assign accept    = bit_valid && bit_ready;
  assign restart   = start && (bit_count != '0);
  assign out_free  = !word_valid || word_ready;
  assign drain     = word_valid && word_ready;

  // A start bit (or the first bit after a transfer) begins from an empty word.
  always_comb begin
    base      = start ? '0 : bit_count;
    pos       = MSB_FIRST ? (WIDTH - 1 - int'(base)) : int'(base);
    next_word = (base == '0) ? '0 : shreg;
    for (int i = 0; i < WIDTH; i++) begin
      if (i == pos) next_word[i] = bit_in;
    end
    complete  = accept && (base == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg      <= '0;
      bit_count  <= '0;
      pending    <= 1'b0;
      word_out   <= '0;
      word_valid <= 1'b0;
      abort      <= 1'b0;
    end else begin
      abort <= accept && restart;
      if (pending) begin
        // No bits are accepted while pending, so only the drain can move state.
        if (drain) begin
          word_out  <= shreg;
          pending   <= 1'b0;
          bit_count <= '0;
        end
      end else if (complete) begin
        if (out_free) begin
          word_out   <= next_word;
          word_valid <= 1'b1;
          bit_count  <= '0;
        end else begin
          shreg     <= next_word;
          pending   <= 1'b1;
          bit_count <= CW'(WIDTH);
        end
      end else begin
        if (accept) begin
          shreg     <= next_word;
          bit_count <= base + CW'(1);
        end
        if (drain) word_valid <= 1'b0;
      end
    end
  end

endmodule
